// File: rtl/nmcu_pkg.sv
// Shared widths and memory-port types for the near-memory compute unit.
package nmcu_pkg;

    parameter int DATA_WIDTH = 32;
    parameter int ADDR_WIDTH = 16;

    typedef struct packed {
        logic                  valid;
        logic                  write_en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] rdata;
    } mem_resp_t;

endpackage

// File: rtl/mem_req_engine_if.sv
// Command, write-data and read-data streams of mem_req_engine.
interface mem_req_engine_if #(
    parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = nmcu_pkg::ADDR_WIDTH,
    parameter int LEN_WIDTH  = 16
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;

    // Command issuer / data producer / data consumer side.
    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready,
        output wr_valid, wr_data,
        input  wr_ready,
        input  rd_valid, rd_data,
        output rd_ready
    );

    // Engine side.
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready,
        input  wr_valid, wr_data,
        output wr_ready,
        output rd_valid, rd_data,
        input  rd_ready
    );

endinterface

// File: rtl/mem_req_engine.sv
// Burst memory request engine: turns read/write burst commands into
// one-word memory requests, buffering read returns in a small FIFO.
module mem_req_engine #(
    parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = nmcu_pkg::ADDR_WIDTH,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_req_engine_if.slave     bus,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output nmcu_pkg::mem_req_t  mem_req_o,
    input  nmcu_pkg::mem_resp_t mem_resp_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_FIN
    } state_e;

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  iss_q, iss_d;     // words issued to memory
    logic [LEN_WIDTH-1:0]  pop_q, pop_d;     // read words handed out
    logic [LEN_WIDTH-1:0]  ack_q, ack_d;     // write acknowledges seen
    logic [LEN_WIDTH-1:0]  out_q, out_d;     // requests awaiting a response
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    nmcu_pkg::mem_req_t    req_q, req_d;
    logic                  err_q, err_d;

    logic resp_ok;
    logic push;
    logic pop;
    logic issue;
    logic wr_hs;

    assign resp_ok     = mem_resp_i.valid && (out_q != '0);
    assign push        = (state_q == S_RD) && resp_ok;
    assign bus.rd_valid = (cnt_q != '0);
    assign bus.rd_data  = fifo_mem_q[rptr_q];
    assign pop         = bus.rd_valid && bus.rd_ready;

    assign mem_req_o = req_q;
    assign err_o     = err_q;

    // Next-state, counters, request register inputs and handshake outputs.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        iss_d         = iss_q;
        pop_d         = pop_q;
        ack_d         = ack_q;
        out_d         = out_q;
        addr_d        = addr_q;
        req_d         = '0;
        err_d         = err_q;
        issue         = 1'b0;
        wr_hs         = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;

        if (mem_resp_i.valid && (out_q == '0)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // rst_n gate keeps cmd_ready low while reset is held.
                bus.cmd_ready = rst_n;
                if (bus.cmd_valid && rst_n) begin
                    len_d  = bus.cmd_len;
                    addr_d = bus.cmd_addr;
                    iss_d  = '0;
                    pop_d  = '0;
                    ack_d  = '0;
                    out_d  = '0;
                    if (bus.cmd_len == '0) begin
                        state_d = S_FIN;
                    end else if (bus.cmd_write) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end

            S_RD: begin
                busy_o = 1'b1;
                // Reserve a FIFO slot per outstanding read so returns never overflow.
                issue = (iss_q < len_q) &&
                        (({1'b0, out_q} + (LEN_WIDTH+1)'(cnt_q)) <
                         (LEN_WIDTH+1)'(FIFO_DEPTH));
                if (issue) begin
                    req_d.valid    = 1'b1;
                    req_d.write_en = 1'b0;
                    req_d.addr     = addr_q;
                    addr_d         = addr_q + ADDR_WIDTH'(1);
                    iss_d          = iss_q + LEN_WIDTH'(1);
                end
                out_d = out_q + LEN_WIDTH'(issue) - LEN_WIDTH'(resp_ok);
                pop_d = pop_q + LEN_WIDTH'(pop);
                if (pop_d == len_q) begin
                    state_d = S_FIN;
                end
            end

            S_WR: begin
                busy_o       = 1'b1;
                bus.wr_ready = (iss_q < len_q);
                wr_hs        = bus.wr_ready && bus.wr_valid;
                if (wr_hs) begin
                    req_d.valid    = 1'b1;
                    req_d.write_en = 1'b1;
                    req_d.addr     = addr_q;
                    req_d.wdata    = bus.wr_data;
                    addr_d         = addr_q + ADDR_WIDTH'(1);
                    iss_d          = iss_q + LEN_WIDTH'(1);
                end
                out_d = out_q + LEN_WIDTH'(wr_hs) - LEN_WIDTH'(resp_ok);
                ack_d = ack_q + LEN_WIDTH'(resp_ok);
                if (ack_d == len_q) begin
                    state_d = S_FIN;
                end
            end

            S_FIN: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Read-return FIFO pointer and occupancy update.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
    end

    // State, counters, FIFO pointers, request register and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            iss_q   <= '0;
            pop_q   <= '0;
            ack_q   <= '0;
            out_q   <= '0;
            addr_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            iss_q   <= iss_d;
            pop_q   <= pop_d;
            ack_q   <= ack_d;
            out_q   <= out_d;
            addr_q  <= addr_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wptr_q] <= mem_resp_i.rdata;
        end
    end

endmodule

// File: tb/tb_mem_req_engine.sv
// Scoreboard bench for mem_req_engine with a latency-3 memory model.
module tb_mem_req_engine;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    mem_req_engine_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .LEN_WIDTH(16)) bus ();

    logic                busy_o;
    logic                done_o;
    logic                err_o;
    nmcu_pkg::mem_req_t  mem_req_o;
    nmcu_pkg::mem_resp_t mem_resp_i;

    mem_req_engine #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16),
        .LEN_WIDTH (16),
        .FIFO_DEPTH(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .mem_req_o (mem_req_o),
        .mem_resp_i(mem_resp_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: 3-cycle read/write response latency, no backpressure.
    logic [31:0] mem_m [0:65535];
    logic        p0v = 1'b0, p1v = 1'b0, p2v = 1'b0;
    logic [31:0] p0d = '0, p1d = '0, p2d = '0;
    logic        nv;
    logic [31:0] nd;
    logic        spur = 1'b0;
    int          cyc = 0;
    int          n_issued = 0;
    int          last_resp_cyc = 0;
    logic [15:0] addr_log [$];

    initial begin
        mem_resp_i = '0;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        nv  = 1'b0;
        nd  = '0;
        if (mem_req_o.valid) begin
            n_issued++;
            addr_log.push_back(mem_req_o.addr);
            nv = 1'b1;
            if (mem_req_o.write_en) mem_m[mem_req_o.addr] = mem_req_o.wdata;
            else                    nd = mem_m[mem_req_o.addr];
        end
        p2v = p1v; p2d = p1d;
        p1v = p0v; p1d = p0d;
        p0v = nv;  p0d = nd;
        #1;
        mem_resp_i.valid = p2v | spur;
        mem_resp_i.rdata = p2d;
        if (p2v) last_resp_cyc = cyc;
    end

    // Scoreboard of expected read words, filled when a read command is driven.
    logic [31:0] exp_q [$];
    int          n_pops   = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;

    always @(negedge clk) begin
        if (rst_n && bus.rd_valid && bus.rd_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                check_val("rd_unexpected", 64'(bus.rd_data), 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                check_val("rd_data", 64'(bus.rd_data), 64'(exp_q.pop_front()));
            end
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic logic [31:0] preload_val(input logic [15:0] a);
        return 32'(a) + 32'h100;
    endfunction

    task automatic push_reads(input logic [15:0] addr, input int len);
        logic [15:0] a;
        for (int i = 0; i < len; i++) begin
            a = addr + 16'(i);
            exp_q.push_back(preload_val(a));
        end
    endtask

    task automatic do_cmd(input logic wr, input logic [15:0] addr, input logic [15:0] len,
                          output int acc);
        int n;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("cmd_accept", 64'(bus.cmd_ready), 64'd1);
        acc = cyc;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input int start_cnt);
        int n;
        n = 0;
        while (done_cnt == start_cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 64'(done_cnt > start_cnt), 64'd1);
    endtask

    task automatic set_rd_ready(input logic v);
        @(posedge clk);
        #1 bus.rd_ready = v;
    endtask

    initial begin
        int          acc;
        int          d0;
        int          n;
        logic [31:0] wdat [3];
        logic [15:0] wrap_exp [4];

        for (int i = 0; i < 65536; i++) mem_m[i] = 32'(i) + 32'h100;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check_val("rst_mem_req",   64'(mem_req_o), 64'd0);
        check_val("rst_rd_valid",  64'(bus.rd_valid), 64'd0);
        check_val("rst_wr_ready",  64'(bus.wr_ready), 64'd0);
        check_val("rst_busy",      64'(busy_o), 64'd0);
        check_val("rst_done",      64'(done_o), 64'd0);
        check_val("rst_err",       64'(err_o), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // Basic read, latency 3, rd_ready always high
        set_rd_ready(1'b1);
        n_issued = 0;
        d0 = done_cnt;
        push_reads(16'h0010, 4);
        do_cmd(1'b0, 16'h0010, 16'd4, acc);
        wait_done("rd_done_timeout", 200, d0);
        repeat (4) @(negedge clk);
        check_val("rd_done_count", 64'(done_cnt - d0), 64'd1);
        check_val("rd_sb_empty",   64'(exp_q.size()), 64'd0);
        check_val("rd_issued",     64'(n_issued), 64'd4);

        // Backpressure: FIFO depth bounds issued reads
        set_rd_ready(1'b0);
        n_issued = 0;
        n_pops   = 0;
        d0 = done_cnt;
        push_reads(16'h0040, 20);
        do_cmd(1'b0, 16'h0040, 16'd20, acc);
        repeat (30) @(negedge clk);
        check_val("bp_issued_cap", 64'(n_issued), 64'd8);
        check_val("bp_rd_valid",   64'(bus.rd_valid), 64'd1);
        check_val("bp_nothing_popped", 64'(exp_q.size()), 64'd20);
        set_rd_ready(1'b1);
        wait_done("bp_done_timeout", 400, d0);
        repeat (4) @(negedge clk);
        check_val("bp_pops",      64'(n_pops), 64'd20);
        check_val("bp_sb_empty",  64'(exp_q.size()), 64'd0);
        check_val("bp_issued",    64'(n_issued), 64'd20);
        check_val("bp_done_count", 64'(done_cnt - d0), 64'd1);

        // Write burst with gapped wr_valid
        wdat[0] = 32'hA5A5_0001;
        wdat[1] = 32'hB6B6_0002;
        wdat[2] = 32'hC7C7_0003;
        d0 = done_cnt;
        do_cmd(1'b1, 16'h0020, 16'd3, acc);
        for (int i = 0; i < 3; i++) begin
            repeat (2) @(negedge clk);
            n = 0;
            while (!bus.wr_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = wdat[i];
            @(posedge clk);
            #1 bus.wr_valid = 1'b0;
        end
        wait_done("wr_done_timeout", 100, d0);
        check_val("wr_done_lat", 64'(done_cyc), 64'(last_resp_cyc + 1));
        repeat (3) @(negedge clk);
        check_val("wr_mem0", 64'(mem_m[16'h0020]), 64'h0000_0000_A5A5_0001);
        check_val("wr_mem1", 64'(mem_m[16'h0021]), 64'h0000_0000_B6B6_0002);
        check_val("wr_mem2", 64'(mem_m[16'h0022]), 64'h0000_0000_C7C7_0003);
        check_val("wr_done_count", 64'(done_cnt - d0), 64'd1);
        check_val("wr_err_clear", 64'(err_o), 64'd0);

        // Address wrap at the top of the address space
        addr_log.delete();
        d0 = done_cnt;
        push_reads(16'hFFFE, 4);
        do_cmd(1'b0, 16'hFFFE, 16'd4, acc);
        wait_done("wrap_done_timeout", 200, d0);
        wrap_exp[0] = 16'hFFFE;
        wrap_exp[1] = 16'hFFFF;
        wrap_exp[2] = 16'h0000;
        wrap_exp[3] = 16'h0001;
        check_val("wrap_count", 64'(addr_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_log.size()) check_val("wrap_addr", 64'(addr_log[i]), 64'(wrap_exp[i]));
        end
        check_val("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

        // Zero-length command: no memory traffic, done in the cycle after acceptance
        n_issued = 0;
        d0 = done_cnt;
        do_cmd(1'b0, 16'h0055, 16'd0, acc);
        wait_done("len0_done_timeout", 20, d0);
        check_val("len0_done_lat", 64'(done_cyc), 64'(acc + 1));
        repeat (5) @(negedge clk);
        check_val("len0_no_req", 64'(n_issued), 64'd0);
        check_val("len0_done_count", 64'(done_cnt - d0), 64'd1);

        // Spurious response while idle sets a sticky error
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (2) @(negedge clk);
        check_val("spur_err_set", 64'(err_o), 64'd1);
        repeat (10) @(negedge clk);
        check_val("spur_err_held", 64'(err_o), 64'd1);

        // Reset in the middle of a read burst
        push_reads(16'h0080, 8);
        do_cmd(1'b0, 16'h0080, 16'd8, acc);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check_val("mid_rst_mem_req",   64'(mem_req_o), 64'd0);
        check_val("mid_rst_rd_valid",  64'(bus.rd_valid), 64'd0);
        check_val("mid_rst_wr_ready",  64'(bus.wr_ready), 64'd0);
        check_val("mid_rst_busy",      64'(busy_o), 64'd0);
        check_val("mid_rst_done",      64'(done_o), 64'd0);
        check_val("mid_rst_err",       64'(err_o), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("late_resp_err", 64'(err_o), 64'd1);
        check_val("post_mid_rst_idle", 64'(bus.cmd_ready), 64'd1);
        check_val("post_mid_rst_busy", 64'(busy_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
